aes_roundtrip_sequencer: RTL and testbench

//  Sequences one shared SPI master through an encrypt-then-decrypt round trip on the AES-128 units.
//  - Encrypt phase: cs routed to the encryption unit; plaintext and key sent; ciphertext captured.
//  - Decrypt phase: cs routed to the decryption unit; ciphertext sent back; recovered text compared to the original.

---
 rtl/aes_roundtrip_sequencer.sv | 169 ++++++++++++++++
 tb/tb_aes_roundtrip_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/aes_roundtrip_sequencer.sv
// Drives one shared SPI master through an encrypt-then-decrypt round trip and checks the recovered text.
// Latency: start->ENC m_start 1 cycle, m_done->next step 1 cycle; start while busy is ignored.
module aes_roundtrip_sequencer #(
   parameter int NB          = 4,
   parameter int TIMEOUT_CYC = 2048,
   parameter int CNT_W       = 8,
   localparam int W          = 32 * NB
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     msg,
   input  logic [W-1:0]     key,
   output logic             busy,
   output logic             m_start,
   output logic [W-1:0]     m_msg,
   output logic [W-1:0]     m_key,
   input  logic             m_done,
   input  logic [W-1:0]     m_result,
   output logic             sel_dec,
   output logic [W-1:0]     cipher,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] pass_cnt,
   output logic             led1,
   output logic             led2,
   output logic             led3
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ENC_START = 3'd1;
   localparam logic [2:0] ENC_WAIT  = 3'd2;
   localparam logic [2:0] DEC_START = 3'd3;
   localparam logic [2:0] DEC_WAIT  = 3'd4;
   localparam logic [2:0] REPORT    = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [W-1:0]     msg_r_q, msg_r_d;
   logic [W-1:0]     m_msg_q, m_msg_d;
   logic [W-1:0]     m_key_q, m_key_d;
   logic [W-1:0]     cipher_q, cipher_d;
   logic             sel_dec_q, sel_dec_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic             match;

   assign match = (m_result == msg_r_q);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      msg_r_d    = msg_r_q;
      m_msg_d    = m_msg_q;
      m_key_d    = m_key_q;
      cipher_d   = cipher_q;
      sel_dec_d  = sel_dec_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      timeout_d  = timeout_q;
      pass_cnt_d = pass_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ENC_START;
               msg_r_d   = msg;
               m_msg_d   = msg;
               m_key_d   = key;
               sel_dec_d = 1'b0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ENC_START: begin
            state_d    = ENC_WAIT;
            wait_cnt_d = '0;
         end
         ENC_WAIT: begin
            // m_done on the last count cycle takes priority over the timeout
            if (m_done) begin
               state_d   = DEC_START;
               cipher_d  = m_result;
               m_msg_d   = m_result;
               sel_dec_d = 1'b1;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = REPORT;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         DEC_START: begin
            state_d    = DEC_WAIT;
            wait_cnt_d = '0;
         end
         DEC_WAIT: begin
            if (m_done) begin
               state_d = REPORT;
               pass_d  = match;
               fail_d  = !match;
               if (match && (pass_cnt_q != {CNT_W{1'b1}}))
                  pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = REPORT;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         REPORT: begin
            state_d   = IDLE;
            sel_dec_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         msg_r_q    <= '0;
         m_msg_q    <= '0;
         m_key_q    <= '0;
         cipher_q   <= '0;
         sel_dec_q  <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         timeout_q  <= 1'b0;
         pass_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         msg_r_q    <= msg_r_d;
         m_msg_q    <= m_msg_d;
         m_key_q    <= m_key_d;
         cipher_q   <= cipher_d;
         sel_dec_q  <= sel_dec_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         timeout_q  <= timeout_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign m_start  = (state_q == ENC_START) || (state_q == DEC_START);
   assign done     = (state_q == REPORT);
   assign m_msg    = m_msg_q;
   assign m_key    = m_key_q;
   assign cipher   = cipher_q;
   assign sel_dec  = sel_dec_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign timeout  = timeout_q;
   assign pass_cnt = pass_cnt_q;
   assign led1     = pass_q;
   assign led2     = fail_q;
   assign led3     = timeout_q;

endmodule

// File: tb/tb_aes_roundtrip_sequencer.sv
// Directed bench: the bench plays the SPI master and checks every handshake against hand-computed values.
module tb_aes_roundtrip_sequencer;

   localparam int TO = 32;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [127:0] msg = '0;
   logic [127:0] key = '0;
   logic         busy, m_start, sel_dec, done, pass, fail, timeout;
   logic [127:0] m_msg, m_key, cipher;
   logic         m_done = 1'b0;
   logic [127:0] m_result = '0;
   logic [7:0]   pass_cnt;
   logic         led1, led2, led3;

   int checks = 0;
   int errors = 0;
   int mstart_cnt = 0;

   aes_roundtrip_sequencer #(.NB(4), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .msg(msg), .key(key),
      .busy(busy), .m_start(m_start), .m_msg(m_msg), .m_key(m_key),
      .m_done(m_done), .m_result(m_result), .sel_dec(sel_dec), .cipher(cipher),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout), .pass_cnt(pass_cnt),
      .led1(led1), .led2(led2), .led3(led3)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (m_start) mstart_cnt++;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Full round trip; ends on the first IDLE negedge after REPORT.
   task automatic roundtrip(input logic [127:0] pt, input logic [127:0] k,
                            input logic [127:0] enc_res, input logic [127:0] dec_res,
                            input bit poke_start);
      @(negedge clk); start = 1'b1; msg = pt; key = k;
      @(negedge clk); start = 1'b0;
      chk("enc_mstart", m_start, 1);
      chk("enc_sel", sel_dec, 0);
      chk("enc_mmsg", m_msg, pt);
      chk("enc_mkey", m_key, k);
      @(negedge clk);
      chk("enc_wait_nostart", m_start, 0);
      m_done = 1'b1; m_result = enc_res;
      @(negedge clk); m_done = 1'b0;
      chk("dec_mstart", m_start, 1);
      chk("dec_sel", sel_dec, 1);
      chk("dec_cipher", cipher, enc_res);
      chk("dec_mmsg", m_msg, enc_res);
      @(negedge clk);
      if (poke_start) begin
         start = 1'b1;
         @(negedge clk); start = 1'b0;
         chk("poke_busy", busy, 1);
         chk("poke_nostart", m_start, 0);
      end
      m_done = 1'b1; m_result = dec_res;
      @(negedge clk); m_done = 1'b0;
      chk("report_done", done, 1);
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sel", sel_dec, 0);
   endtask

   initial begin
      int n;
      bit sel_seen;
      int base;

      // reset state
      #12;
      chk("rst_busy", busy, 0);      chk("rst_mstart", m_start, 0);
      chk("rst_mmsg", m_msg, 0);     chk("rst_mkey", m_key, 0);
      chk("rst_sel", sel_dec, 0);    chk("rst_cipher", cipher, 0);
      chk("rst_done", done, 0);      chk("rst_pass", pass, 0);
      chk("rst_fail", fail, 0);      chk("rst_timeout", timeout, 0);
      chk("rst_cnt", pass_cnt, 0);   chk("rst_leds", {led1, led2, led3}, 0);
      @(negedge clk); rst = 1'b1;

      // FIPS-197 vector
      roundtrip(PT, KY, CT, PT, 1'b0);
      chk("fips_cipher", cipher, CT);
      chk("fips_pass", pass, 1);     chk("fips_fail", fail, 0);
      chk("fips_led1", led1, 1);     chk("fips_cnt", pass_cnt, 1);

      // corrupted decrypt
      roundtrip(PT, KY, CT, PT ^ 128'h1, 1'b0);
      chk("bad_fail", fail, 1);      chk("bad_pass", pass, 0);
      chk("bad_led2", led2, 1);      chk("bad_led1", led1, 0);
      chk("bad_cnt", pass_cnt, 1);

      // encrypt-phase timeout
      @(negedge clk); start = 1'b1; msg = PT; key = KY;
      @(negedge clk); start = 1'b0;
      chk("to_mstart", m_start, 1);
      chk("to_fail_clr", fail, 0);
      n = 0; sel_seen = 0;
      while (n < TO + 8 && !timeout) begin
         @(posedge clk); n++; #1;
         if (sel_dec) sel_seen = 1;
      end
      chk("to_latency", n, TO + 1);
      @(negedge clk);
      chk("to_flag", timeout, 1);    chk("to_led3", led3, 1);
      chk("to_done", done, 1);       chk("to_sel_never", sel_seen, 0);
      chk("to_pass", pass, 0);       chk("to_fail", fail, 0);
      @(negedge clk);
      chk("to_idle", busy, 0);       chk("to_sticky", timeout, 1);

      // m_done on the final count cycle wins over timeout
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("edge_to_clr", timeout, 0);
      repeat (TO) @(negedge clk);
      m_done = 1'b1; m_result = CT;
      @(negedge clk); m_done = 1'b0;
      chk("edge_dec_mstart", m_start, 1);
      chk("edge_sel", sel_dec, 1);
      chk("edge_no_to", timeout, 0);
      @(negedge clk); m_done = 1'b1; m_result = PT;
      @(negedge clk); m_done = 1'b0;
      chk("edge_pass", pass, 1);     chk("edge_cnt", pass_cnt, 2);
      @(negedge clk);

      // stray m_done in IDLE, start during DEC_WAIT
      @(negedge clk); m_done = 1'b1; m_result = 128'hdead;
      @(negedge clk); m_done = 1'b0;
      chk("stray_busy", busy, 0);    chk("stray_cipher", cipher, CT);
      chk("stray_pass", pass, 1);    chk("stray_cnt", pass_cnt, 2);
      base = mstart_cnt;
      roundtrip(PT, KY, CT, PT, 1'b1);
      repeat (3) @(negedge clk);
      chk("poke_mstarts", mstart_cnt - base, 2);
      chk("poke_idle", busy, 0);     chk("poke_cnt", pass_cnt, 3);

      // async reset in DEC_WAIT
      @(negedge clk); start = 1'b1; msg = PT; key = KY;
      @(negedge clk); start = 1'b0;
      @(negedge clk); m_done = 1'b1; m_result = CT;
      @(negedge clk); m_done = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);     chk("arst_sel", sel_dec, 0);
      chk("arst_cipher", cipher, 0); chk("arst_mmsg", m_msg, 0);
      chk("arst_mkey", m_key, 0);    chk("arst_cnt", pass_cnt, 0);
      chk("arst_pass", pass, 0);     chk("arst_mstart", m_start, 0);
      @(negedge clk); rst = 1'b1;
      roundtrip(PT, KY, CT, PT, 1'b0);
      chk("arst_fresh_pass", pass, 1);
      chk("arst_fresh_cnt", pass_cnt, 1);

      // saturation of the pass counter
      for (int i = 0; i < 253; i++) roundtrip(PT, KY, CT, PT, 1'b0);
      chk("sat_fe", pass_cnt, 8'hFE);
      for (int i = 0; i < 4; i++) roundtrip(PT, KY, CT, PT, 1'b0);
      chk("sat_ff", pass_cnt, 8'hFF);
      chk("sat_pass", pass, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
